// File: rtl/axi_wgen_pkg.sv
// Shared types and helpers for the AXI3 write-data generator.
// Command fields are sized for the widest supported ID/address; the top truncates.
package axi_wgen_pkg;

  localparam int ID_W_MAX   = 16;
  localparam int ADDR_W_MAX = 64;
  localparam int STRB_W_MAX = 32;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam int RDY_ALWAYS   = 0;
  localparam int RDY_RANDOM   = 1;
  localparam int RDY_PERIODIC = 2;

  // Galois form of x^32 + x^22 + x^2 + x + 1, right-shifting.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef struct packed {
    logic [ID_W_MAX-1:0]   id;
    logic [ADDR_W_MAX-1:0] addr;
    logic [3:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_cmd_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Bytes from the lane offset up to the next 2^size boundary.
  function automatic logic [STRB_W_MAX-1:0] strb_calc(input logic [4:0] off,
                                                      input logic [2:0] size);
    logic [4:0]            hi;
    logic [STRB_W_MAX-1:0] s;
    hi = off | ((5'd1 << size) - 5'd1);
    s  = '0;
    for (int i = 0; i < STRB_W_MAX; i++)
      s[i] = (5'(i) >= off) && (5'(i) <= hi);
    return s;
  endfunction

endpackage

// File: rtl/wgen_cmd_fifo.sv
// First-word fall-through queue of accepted AW commands.
module wgen_cmd_fifo
  import axi_wgen_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  aw_cmd_t          push_cmd,
  output aw_cmd_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  aw_cmd_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_mst_wgen.sv
// AXI3 master-side W generator: queues snooped AW commands and emits matching
// W bursts with LFSR data, plus bready/rready under a selectable policy.
module axi_mst_wgen
  import axi_wgen_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          ID_W       = 4,
  parameter int          DATA_W     = 32,
  parameter int          OSTD_NUM   = 4,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2357,
  parameter int          RDY_MODE   = 1,
  parameter int          RDY_PERIOD = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                srst,
  input  logic                awvalid,
  input  logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                bready,
  output logic                rready,
  output logic                ostd_full,
  output logic                err_ovf
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(OSTD_NUM) + 1;
  localparam int PER_W = $clog2(RDY_PERIOD);

  aw_cmd_t               push_cmd;
  aw_cmd_t               head;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic [3:0]            beat_cnt;
  logic [ADDR_W-1:0]     beat_addr;
  logic [ADDR_W-1:0]     cur_addr;
  logic [ADDR_W-1:0]     nxt_addr;
  logic [ADDR_W-1:0]     size_b;
  logic [ADDR_W-1:0]     incr_addr;
  logic [ADDR_W-1:0]     win;
  logic                  wrap_ok;
  logic [31:0]           data_lfsr;
  logic [31:0]           rdy_lfsr;
  logic [PER_W-1:0]      rdy_cnt;
  logic [STRB_W_MAX-1:0] strb_all;
  logic [NB-1:0]         strb;
  logic                  unused_bits;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign pop   = w_hs && wlast;
  assign push  = aw_hs && (!full || pop);

  always_comb begin
    push_cmd       = '0;
    push_cmd.id    = ID_W_MAX'(awid);
    push_cmd.addr  = ADDR_W_MAX'(awaddr);
    push_cmd.len   = awlen;
    push_cmd.size  = awsize;
    push_cmd.burst = awburst;
  end

  wgen_cmd_fifo #(.DEPTH(OSTD_NUM)) u_cmd_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .srst     (srst),
    .push     (push),
    .pop      (pop),
    .push_cmd (push_cmd),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign ostd_full = full;

  // Beat 0 always takes the head address so a new burst needs no load cycle.
  assign cur_addr  = (beat_cnt == 4'd0) ? head.addr[ADDR_W-1:0] : beat_addr;
  assign size_b    = ADDR_W'(1) << head.size;
  assign incr_addr = (cur_addr & ~(size_b - ADDR_W'(1))) + size_b;
  assign win       = (ADDR_W'(head.len) + ADDR_W'(1)) << head.size;
  assign wrap_ok   = (head.len == 4'd1) || (head.len == 4'd3) ||
                     (head.len == 4'd7) || (head.len == 4'd15);

  always_comb begin
    nxt_addr = incr_addr;
    if (head.burst == BURST_FIXED)
      nxt_addr = cur_addr;
    else if (head.burst == BURST_WRAP && wrap_ok)
      nxt_addr = (cur_addr & ~(win - ADDR_W'(1))) | (incr_addr & (win - ADDR_W'(1)));
  end

  assign strb_all = strb_calc(5'(cur_addr & ADDR_W'(NB - 1)), head.size);

  always_comb begin
    wvalid = !empty;
    wlast  = !empty && (beat_cnt == head.len);
    wid    = empty ? '0 : head.id[ID_W-1:0];
    strb   = empty ? '0 : strb_all[NB-1:0];
    wstrb  = strb;
    wdata  = '0;
    for (int b = 0; b < NB; b++)
      wdata[8*b +: 8] = strb[b] ? data_lfsr[8*(b%4) +: 8] : 8'h00;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt  <= '0;
      beat_addr <= '0;
      data_lfsr <= LFSR_SEED;
      err_ovf   <= 1'b0;
    end else if (srst) begin
      beat_cnt  <= '0;
      beat_addr <= '0;
      data_lfsr <= LFSR_SEED;
      err_ovf   <= 1'b0;
    end else begin
      if (w_hs) begin
        data_lfsr <= lfsr_step(data_lfsr);
        if (wlast) begin
          beat_cnt <= '0;
        end else begin
          beat_cnt  <= beat_cnt + 4'd1;
          beat_addr <= nxt_addr;
        end
      end
      if (aw_hs && full && !pop) err_ovf <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_lfsr <= ~LFSR_SEED;
      rdy_cnt  <= '0;
      bready   <= 1'b0;
      rready   <= 1'b0;
    end else if (srst) begin
      rdy_lfsr <= ~LFSR_SEED;
      rdy_cnt  <= '0;
      bready   <= 1'b0;
      rready   <= 1'b0;
    end else begin
      rdy_lfsr <= lfsr_step(rdy_lfsr);
      rdy_cnt  <= (rdy_cnt == PER_W'(RDY_PERIOD - 1)) ? '0 : rdy_cnt + PER_W'(1);
      case (RDY_MODE)
        RDY_RANDOM: begin
          bready <= rdy_lfsr[0];
          rready <= rdy_lfsr[1];
        end
        RDY_PERIODIC: begin
          bready <= (rdy_cnt == PER_W'(RDY_PERIOD - 1));
          rready <= (rdy_cnt == PER_W'(RDY_PERIOD - 1));
        end
        default: begin
          bready <= 1'b1;
          rready <= 1'b1;
        end
      endcase
    end
  end

  assign unused_bits = ^{head.id, head.addr, strb_all, count};

endmodule

// File: tb/tb_axi_mst_wgen.sv
// Directed bench for axi_mst_wgen: bursts, strobes, queue full, reset, ready policies.
module tb_axi_mst_wgen;

  localparam int          ADDR_W = 32;
  localparam int          ID_W   = 4;
  localparam int          DATA_W = 32;
  localparam logic [31:0] SEED   = 32'hACE1_2357;

  logic              aclk = 1'b0;
  logic              aresetn, srst;
  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wready;
  logic              wvalid, wlast, bready, rready, ostd_full, err_ovf;
  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid_0, wlast_0, bready_0, rready_0, ostd_full_0, err_ovf_0;
  logic [ID_W-1:0]   wid_0;
  logic [DATA_W-1:0] wdata_0;
  logic [3:0]        wstrb_0;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_lfsr;
  int          ones, ones_0;

  always #5 aclk = ~aclk;

  axi_mst_wgen #(.RDY_MODE(2), .RDY_PERIOD(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .bready(bready), .rready(rready),
    .ostd_full(ostd_full), .err_ovf(err_ovf)
  );

  axi_mst_wgen #(.RDY_MODE(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid_0), .wready(wready), .wid(wid_0), .wdata(wdata_0), .wstrb(wstrb_0),
    .wlast(wlast_0), .bready(bready_0), .rready(rready_0),
    .ostd_full(ostd_full_0), .err_ovf(err_ovf_0)
  );

  function automatic logic [31:0] tb_lfsr(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    awvalid = 1'b1; awready = 1'b1;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    cyc();
    awvalid = 1'b0;
  endtask

  // Checks the beat on display now (wready high), then lets it hand off.
  task automatic beat(input logic [3:0] id, input logic [3:0] strb, input logic last,
                      input logic [31:0] addr);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
    chk("wvalid", 64'(wvalid), 64'd1);
    chk("wid", 64'(wid), 64'(id));
    chk("wstrb", 64'(wstrb), 64'(strb));
    chk("wlast", 64'(wlast), 64'(last));
    chk("wdata", 64'(wdata), 64'(exp_lfsr & mask));
    chk("beat_addr", 64'(dut.cur_addr), 64'(addr));
    cyc();
    exp_lfsr = tb_lfsr(exp_lfsr);
  endtask

  initial begin
    aresetn = 1'b0; srst = 1'b0; awvalid = 1'b0; awready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wready = 1'b0;
    exp_lfsr = SEED;
    repeat (3) cyc();
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_wlast", 64'(wlast), 64'd0);
    chk("rst_wstrb", 64'(wstrb), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_wid", 64'(wid), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_bready_m0", 64'(bready_0), 64'd0);
    chk("rst_full", 64'(ostd_full), 64'd0);
    chk("rst_ovf", 64'(err_ovf), 64'd0);
    aresetn = 1'b1;
    cyc();
    chk("m0_first_bready", 64'(bready_0), 64'd1);
    chk("m0_first_rready", 64'(rready_0), 64'd1);

    // aligned INCR
    wready = 1'b1;
    send_aw(4'd3, 32'h100, 4'd3, 3'd2, 2'd1);
    beat(4'd3, 4'hF, 1'b0, 32'h100);
    beat(4'd3, 4'hF, 1'b0, 32'h104);
    beat(4'd3, 4'hF, 1'b0, 32'h108);
    beat(4'd3, 4'hF, 1'b1, 32'h10C);
    chk("idle_after_incr", 64'(wvalid), 64'd0);

    // narrow unaligned INCR
    send_aw(4'd1, 32'h101, 4'd3, 3'd0, 2'd1);
    beat(4'd1, 4'h2, 1'b0, 32'h101);
    beat(4'd1, 4'h4, 1'b0, 32'h102);
    beat(4'd1, 4'h8, 1'b0, 32'h103);
    beat(4'd1, 4'h1, 1'b1, 32'h104);

    // WRAP, word and byte sized
    send_aw(4'd5, 32'h10C, 4'd3, 3'd2, 2'd2);
    beat(4'd5, 4'hF, 1'b0, 32'h10C);
    beat(4'd5, 4'hF, 1'b0, 32'h100);
    beat(4'd5, 4'hF, 1'b0, 32'h104);
    beat(4'd5, 4'hF, 1'b1, 32'h108);
    send_aw(4'd6, 32'h10E, 4'd3, 3'd0, 2'd2);
    beat(4'd6, 4'h4, 1'b0, 32'h10E);
    beat(4'd6, 4'h8, 1'b0, 32'h10F);
    beat(4'd6, 4'h1, 1'b0, 32'h10C);
    beat(4'd6, 4'h2, 1'b1, 32'h10D);

    // queue full, back-pressure, overflow
    wready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_aw(4'(4 + i), 32'h200 + 32'(16 * i), 4'd1, 3'd2, 2'd1);
    chk("full_set", 64'(ostd_full), 64'd1);
    chk("ovf_clear", 64'(err_ovf), 64'd0);
    repeat (2) begin
      cyc();
      chk("stall_wvalid", 64'(wvalid), 64'd1);
      chk("stall_wid", 64'(wid), 64'd4);
      chk("stall_wdata", 64'(wdata), 64'(exp_lfsr));
      chk("stall_wlast", 64'(wlast), 64'd0);
    end
    send_aw(4'd8, 32'h300, 4'd0, 3'd2, 2'd1);
    chk("ovf_set", 64'(err_ovf), 64'd1);
    chk("full_hold", 64'(ostd_full), 64'd1);
    wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(4'(4 + i), 4'hF, 1'b0, 32'h200 + 32'(16 * i));
      beat(4'(4 + i), 4'hF, 1'b1, 32'h204 + 32'(16 * i));
    end
    chk("drained_wvalid", 64'(wvalid), 64'd0);
    chk("drained_full", 64'(ostd_full), 64'd0);
    chk("ovf_sticky", 64'(err_ovf), 64'd1);

    // async reset mid-burst
    send_aw(4'd2, 32'h300, 4'd3, 3'd2, 2'd1);
    beat(4'd2, 4'hF, 1'b0, 32'h300);
    chk("mid_burst_wvalid", 64'(wvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("async_wvalid", 64'(wvalid), 64'd0);
    chk("async_wdata", 64'(wdata), 64'd0);
    chk("async_ovf", 64'(err_ovf), 64'd0);
    cyc();
    aresetn = 1'b1;
    exp_lfsr = SEED;
    send_aw(4'd9, 32'h400, 4'd0, 3'd2, 2'd1);
    chk("post_rst_seed", 64'(wdata), 64'(SEED));
    beat(4'd9, 4'hF, 1'b1, 32'h400);

    // ready policies
    ones = 0; ones_0 = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      ones += int'(bready);
      ones_0 += int'(bready_0);
      chk("rready_eq_bready", 64'(rready), 64'(bready));
    end
    chk("periodic_ones", 64'(ones), 64'd4);
    chk("always_ones", 64'(ones_0), 64'd16);

    // synchronous clear
    wready = 1'b0;
    send_aw(4'd1, 32'h500, 4'd0, 3'd2, 2'd1);
    chk("pre_srst_wvalid", 64'(wvalid), 64'd1);
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    chk("srst_wvalid", 64'(wvalid), 64'd0);
    chk("srst_bready", 64'(bready_0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
